// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the MIPS pipeline stage registers.
package pipe_pkg;

  localparam int          TNEW_W_DEF = 2;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] PC_RST_DEF = 32'h0000_3000;

  typedef logic [TNEW_W_DEF-1:0] tnew_t;

endpackage

// File: rtl/pipe_stage_reg_tnew_sat_dec.sv
// Saturating decrement of the hazard-unit Tnew countdown.
// Purely combinational; shared with the hazard unit.
module tnew_sat_dec #(
  parameter int TNEW_W = 2
) (
  input  logic [TNEW_W-1:0] tnew_in,
  output logic [TNEW_W-1:0] tnew_dec
);

  // Stop at zero instead of wrapping to all-ones.
  assign tnew_dec = (tnew_in == '0) ? '0 : tnew_in - TNEW_W'(1);

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with
// stall hold, flush-to-bubble and valid tracking.
// Optional hold/bubble performance counters: define PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter int              TNEW_W   = 2,
  parameter bit              DEC_TNEW = 1'b1,
  parameter logic [PC_W-1:0] PC_RST   = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] data_a_in,
  input  logic [DATA_W-1:0] data_b_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [TNEW_W-1:0] tnew_in,
  output logic              valid_out,
  output logic [31:0]       instr_out,
  output logic [DATA_W-1:0] data_a_out,
  output logic [DATA_W-1:0] data_b_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [TNEW_W-1:0] tnew_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [TNEW_W-1:0] tnew_load;
  logic              load_bubble;
  logic              hold;

  // ID/EX passes Tnew through; later stages count it down by one per stage.
  generate
    if (DEC_TNEW) begin : g_dec
      tnew_sat_dec #(.TNEW_W(TNEW_W)) u_tnew_dec (
        .tnew_in  (tnew_in),
        .tnew_dec (tnew_load)
      );
    end else begin : g_pass
      assign tnew_load = tnew_in;
    end
  endgenerate

  // Flush wins over stall; an unstalled edge with no real instruction also
  // loads a bubble.
  assign load_bubble = flush | (~stall & ~valid_in);
  assign hold        = stall & ~flush;

  // Stage contents: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (reset || load_bubble) begin
      valid_out  <= 1'b0;
      instr_out  <= NOP_INSTR;
      data_a_out <= '0;
      data_b_out <= '0;
      pc_out     <= PC_RST;
      tnew_out   <= '0;
    end else if (!hold) begin
      valid_out  <= 1'b1;
      instr_out  <= instr_in;
      data_a_out <= data_a_in;
      data_b_out <= data_b_in;
      pc_out     <= pc_in;
      tnew_out   <= tnew_load;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Saturating hold and bubble counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (hold && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (load_bubble && bubble_q != '1)
        bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios from the test
// plan plus randomized traffic against a behavioural model of the stage.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int          DATA_W  = 32;
  localparam int          PC_W    = 32;
  localparam int          TNEW_W  = 2;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] PC_RST  = PC_RST_DEF;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, stall, flush, valid_in;
  logic [31:0]       instr_in;
  logic [DATA_W-1:0] data_a_in, data_b_in;
  logic [PC_W-1:0]   pc_in;
  logic [TNEW_W-1:0] tnew_in;

  logic              valid_out, valid_nd;
  logic [31:0]       instr_out, instr_nd;
  logic [DATA_W-1:0] data_a_out, data_b_out, data_a_nd, data_b_nd;
  logic [PC_W-1:0]   pc_out, pc_nd;
  logic [TNEW_W-1:0] tnew_out, tnew_nd;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt, stall_cnt_nd, bubble_cnt_nd;

  int errors = 0;
  int checks = 0;

  // Behavioural model of one stage slot and its counters.
  bit          m_valid;
  logic [31:0] m_instr, m_a, m_b, m_pc;
  int          m_tnew_dec, m_tnew_pass, m_stalls, m_bubbles;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .TNEW_W(TNEW_W), .DEC_TNEW(1'b1),
                   .PC_RST(PC_RST), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .data_a_in(data_a_in), .data_b_in(data_b_in),
    .pc_in(pc_in), .tnew_in(tnew_in),
    .valid_out(valid_out), .instr_out(instr_out), .data_a_out(data_a_out),
    .data_b_out(data_b_out), .pc_out(pc_out), .tnew_out(tnew_out),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .TNEW_W(TNEW_W), .DEC_TNEW(1'b0),
                   .PC_RST(PC_RST), .CNT_W(CNT_W)) u_dut_nd (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .data_a_in(data_a_in), .data_b_in(data_b_in),
    .pc_in(pc_in), .tnew_in(tnew_in),
    .valid_out(valid_nd), .instr_out(instr_nd), .data_a_out(data_a_nd),
    .data_b_out(data_b_nd), .pc_out(pc_nd), .tnew_out(tnew_nd),
    .stall_cnt(stall_cnt_nd), .bubble_cnt(bubble_cnt_nd)
  );

  // Advance one edge and update the model from the inputs seen at that edge.
  task automatic tick();
    bit bubble;
    @(posedge clk);
    bubble = 1'b0;
    if (reset) begin
      bubble = 1'b1;
      m_stalls = 0;
      m_bubbles = 0;
    end else if (flush || (!stall && !valid_in)) begin
      bubble = 1'b1;
      if (m_bubbles < CNT_MAX) m_bubbles++;
    end else if (stall) begin
      if (m_stalls < CNT_MAX) m_stalls++;
    end else begin
      m_valid     = 1'b1;
      m_instr     = instr_in;
      m_a         = data_a_in;
      m_b         = data_b_in;
      m_pc        = pc_in;
      m_tnew_pass = int'(tnew_in);
      m_tnew_dec  = (int'(tnew_in) > 0) ? int'(tnew_in) - 1 : 0;
    end
    if (bubble) begin
      m_valid = 1'b0; m_instr = 32'h0; m_a = '0; m_b = '0;
      m_pc = PC_RST; m_tnew_pass = 0; m_tnew_dec = 0;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input int tn);
    valid_in  = v;
    instr_in  = ins;
    pc_in     = pc;
    tnew_in   = TNEW_W'(tn);
    data_a_in = $urandom;
    data_b_in = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'h1234, 3);
    tick(); tick();
    checks++;
    if ({valid_out, instr_out, data_a_out, data_b_out, pc_out, tnew_out} !==
        {1'b0, 32'h0, 32'h0, 32'h0, PC_RST, 2'd0}) begin
      errors++;
      $display("FAIL reset_fields: got v=%0b i=%h a=%h b=%h pc=%h t=%0d, want all zero pc=%h",
               valid_out, instr_out, data_a_out, data_b_out, pc_out, tnew_out, PC_RST);
    end
    checks++;
    if ({stall_cnt, bubble_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got stall=%0d bubble=%0d, want 0 0", stall_cnt, bubble_cnt);
    end
    reset = 1'b0; stall = 1'b0;
  endtask

  task automatic test_load();
    logic [31:0] a, b;
    drive(1'b1, 32'h8C43_0004, 32'h3008, 2);
    a = data_a_in; b = data_b_in;
    tick();
    checks++;
    if ({valid_out, instr_out, pc_out, tnew_out, data_a_out, data_b_out} !==
        {1'b1, 32'h8C43_0004, 32'h3008, 2'd1, a, b}) begin
      errors++;
      $display("FAIL load: got v=%0b i=%h pc=%h t=%0d a=%h b=%h, want 1 8c430004 3008 1 %h %h",
               valid_out, instr_out, pc_out, tnew_out, data_a_out, data_b_out, a, b);
    end
    checks++;
    if (tnew_nd !== 2'd2) begin
      errors++;
      $display("FAIL load_nodec_tnew: got %0d want 2", tnew_nd);
    end
  endtask

  task automatic test_tnew_sat();
    drive(1'b1, 32'h0001_0002, 32'h300C, 0);
    tick();
    checks++;
    if (tnew_out !== 2'd0) begin
      errors++;
      $display("FAIL tnew_saturate: got %0d want 0", tnew_out);
    end
    drive(1'b1, 32'h0001_0003, 32'h3010, 3);
    tick();
    checks++;
    if ({tnew_out, tnew_nd} !== {2'd2, 2'd3}) begin
      errors++;
      $display("FAIL tnew_max: got dec=%0d pass=%0d want 2 3", tnew_out, tnew_nd);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'hAAAA_0001, 32'h3020, 3);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hBBBB_0002, 32'h3024, 2);
      tick();
      checks++;
      if ({valid_out, instr_out, pc_out, tnew_out} !== {1'b1, 32'hAAAA_0001, 32'h3020, 2'd2}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%0b i=%h pc=%h t=%0d want 1 aaaa0001 3020 2",
                 i, valid_out, instr_out, pc_out, tnew_out);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({instr_out, pc_out, tnew_out} !== {32'hBBBB_0002, 32'h3024, 2'd1}) begin
      errors++;
      $display("FAIL stall_release: got i=%h pc=%h t=%0d want bbbb0002 3024 1",
               instr_out, pc_out, tnew_out);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'hCCCC_0003, 32'h3030, 3);
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    checks++;
    if ({valid_out, instr_out, pc_out, tnew_out, data_a_out} !==
        {1'b0, 32'h0, PC_RST, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL stall_flush: got v=%0b i=%h pc=%h t=%0d a=%h want bubble",
               valid_out, instr_out, pc_out, tnew_out, data_a_out);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset_in_stall();
    drive(1'b1, 32'hDDDD_0004, 32'h3040, 2);
    tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    checks++;
    if ({valid_out, instr_out, data_b_out, pc_out, tnew_out} !==
        {1'b0, 32'h0, 32'h0, PC_RST, 2'd0}) begin
      errors++;
      $display("FAIL reset_in_stall: got v=%0b i=%h b=%h pc=%h t=%0d want reset values",
               valid_out, instr_out, data_b_out, pc_out, tnew_out);
    end
    stall = 1'b0; reset = 1'b0;
    drive(1'b0, 32'hEEEE_0005, 32'h3050, 3);
    tick();
    checks++;
    if ({valid_out, instr_out, pc_out, tnew_out, data_a_out} !==
        {1'b0, 32'h0, PC_RST, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL invalid_load_bubble: got v=%0b i=%h pc=%h t=%0d a=%h want bubble",
               valid_out, instr_out, pc_out, tnew_out, data_a_out);
    end
  endtask

  task automatic test_perf_counters();
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b1, 32'h1111_0000, 32'h3060, 1);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    stall = 1'b0;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 0);
    tick();
    checks++;
    if ({stall_cnt, bubble_cnt} !== {CNT_W'(PERF ? 5 : 0), CNT_W'(PERF ? 3 : 0)}) begin
      errors++;
      $display("FAIL perf_counts: got stall=%0d bubble=%0d want %0d %0d",
               stall_cnt, bubble_cnt, PERF ? 5 : 0, PERF ? 3 : 0);
    end
    stall = 1'b1;
    for (int i = 0; i < CNT_MAX + 5; i++) tick();
    flush = 1'b1;
    for (int i = 0; i < CNT_MAX + 5; i++) tick();
    stall = 1'b0; flush = 1'b0;
    checks++;
    if ({stall_cnt, bubble_cnt} !== {CNT_W'(PERF ? CNT_MAX : 0), CNT_W'(PERF ? CNT_MAX : 0)}) begin
      errors++;
      $display("FAIL perf_saturate: got stall=%0d bubble=%0d want %0d %0d",
               stall_cnt, bubble_cnt, PERF ? CNT_MAX : 0, PERF ? CNT_MAX : 0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, int'($urandom_range(0, 3)));
      tick();
      checks++;
      if ({valid_out, instr_out, data_a_out, data_b_out, pc_out, tnew_out, tnew_nd,
           valid_nd, instr_nd, data_a_nd, data_b_nd, pc_nd} !==
          {m_valid, m_instr, m_a, m_b, m_pc, TNEW_W'(m_tnew_dec), TNEW_W'(m_tnew_pass),
           m_valid, m_instr, m_a, m_b, m_pc}) begin
        errors++;
        $display("FAIL random_fields[%0d]: got v=%0b i=%h pc=%h t=%0d/%0d want v=%0b i=%h pc=%h t=%0d/%0d",
                 n, valid_out, instr_out, pc_out, tnew_out, tnew_nd,
                 m_valid, m_instr, m_pc, m_tnew_dec, m_tnew_pass);
      end
      checks++;
      if ({stall_cnt, bubble_cnt} !== {CNT_W'(PERF ? m_stalls : 0), CNT_W'(PERF ? m_bubbles : 0)}) begin
        errors++;
        $display("FAIL random_counters[%0d]: got stall=%0d bubble=%0d want %0d %0d",
                 n, stall_cnt, bubble_cnt, PERF ? m_stalls : 0, PERF ? m_bubbles : 0);
      end
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 0);
    test_reset();
    test_load();
    test_tnew_sat();
    test_stall();
    test_stall_flush();
    test_reset_in_stall();
    test_perf_counters();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage MIPS core; one instance replaces each fixed ID/EX, EX/MEM and MEM/WB register.
- Carries instruction word, two data words, PC, a valid bit and the hazard-unit Tnew countdown.
- Adds hold (stall), bubble insertion (flush) and valid tracking; the fixed registers had none of these.

Parameters:
- DATA_W, 32, width of data_a (ALU result / address) and data_b (store data / rt value)
- PC_W, 32, width of PC field
- TNEW_W, 2, width of Tnew countdown
- DEC_TNEW, 1, 1: Tnew saturating-decrements on load; 0: Tnew passes unchanged (for ID/EX use)
- PC_RST, 0, PC value on reset and in inserted bubbles
- CNT_W, 16, width of optional performance counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold current contents
- flush  in  1  replace contents with bubble on next edge
- valid_in  in  1  upstream slot holds a real instruction
- instr_in  in  32  instruction word
- data_a_in  in  DATA_W  first data word
- data_b_in  in  DATA_W  second data word
- pc_in  in  PC_W  instruction PC
- tnew_in  in  TNEW_W  cycles until result is available, as seen upstream
- valid_out  out  1  registered valid
- instr_out  out  32  registered instruction
- data_a_out  out  DATA_W  registered data_a
- data_b_out  out  DATA_W  registered data_b
- pc_out  out  PC_W  registered PC
- tnew_out  out  TNEW_W  registered Tnew
- stall_cnt  out  CNT_W  hold cycles (optional feature only)
- bubble_cnt  out  CNT_W  bubbles loaded (optional feature only)

Behaviour:
- All outputs are registers. Latency: 1 cycle from inputs to outputs on a load edge.
- Per-edge priority: reset > flush > stall > load.
- reset=1: valid, instr, data_a, data_b, tnew = 0; pc = PC_RST.
- flush=1, not in reset: load a bubble (same values as reset). Flush wins over a simultaneous stall; the held instruction is discarded.
- stall=1, no flush: every field keeps its value, including tnew (no decrement while held).
- Load (stall=0, flush=0):
  - valid_in=1: capture all inputs.
  - valid_in=0: capture a bubble; instr=0 (sll $0 nop), tnew=0, pc=PC_RST, data fields=0.
- Tnew on load:
  - DEC_TNEW=1: tnew_out = (tnew_in==0) ? 0 : tnew_in-1. Saturates at 0 and never wraps to all-ones.
  - DEC_TNEW=0: tnew_out = tnew_in.
- No output depends combinationally on any input.
- Reset asserted mid-stall clears the stage and overrides the stall.
- A stage-level state machine is not required; the stage state is valid=0 (EMPTY) or valid=1 (FULL). Transitions follow the priority list above.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments on every non-reset edge with stall=1 and flush=0.
  - bubble_cnt increments on every non-reset edge that loads a bubble (flush=1, or load with valid_in=0).
  - Both counters saturate at all-ones and clear on reset.
- Undefined: stall_cnt and bubble_cnt are tied to 0 and no counter flops are built.

Decomposition:
- Package pipe_pkg holds:
  - TNEW_W_DEF=2
  - NOP_INSTR=32'h0000_0000
  - PC_RST_DEF=32'h0000_3000
  - typedef tnew_t of logic [TNEW_W_DEF-1:0]
- One sub-module, tnew_sat_dec: combinational saturating decrement, width parameter TNEW_W. Shared with the hazard unit.

Test Plan:
- Reset, then load valid_in=1, instr=32'h8C43_0004, pc=32'h3008, tnew_in=2 with DEC_TNEW=1 -> next cycle valid_out=1, instr_out=32'h8C43_0004, pc_out=32'h3008, tnew_out=1.
- tnew_in=0 with DEC_TNEW=1 -> tnew_out=0 (no wrap to 3). Same stimulus with DEC_TNEW=0 and tnew_in=2 -> tnew_out=2.
- Load instr A, then hold stall=1 for 3 cycles while inputs change to B -> outputs stay A with tnew unchanged. Release stall -> B appears one cycle later.
- stall=1 and flush=1 on the same edge -> valid_out=0, instr_out=0, pc_out=PC_RST, tnew_out=0.
- Assert reset during a stall with a valid instruction held -> all fields at reset values the next cycle. Then valid_in=0 load -> bubble output.
- With PIPE_STAGE_PERF_EN defined: 5 stall edges, 2 flush edges and 1 valid_in=0 load -> stall_cnt=5, bubble_cnt=3. Force both counters to all-ones -> both hold at all-ones.
